// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: 8N1 frames on tx, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             tx,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       full_w;
    logic       empty_w;
    logic       push;
    logic       pop;
    logic       baud_done;
    logic [7:0] head;

    // Status comes only from the registered count, so wr_en never reaches full/empty.
    assign full_w    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_w   = (count_q == '0);
    assign push      = wr_en & ~full_w;
    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign head      = mem_q[rd_ptr_q];

    // Storage is a plain register file, written one entry at a time.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty_w) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty_w) begin
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = head;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (pop) begin
            parity_d = ^head;
        end
    end
`endif

    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        overflow_d = overflow_q | (wr_en & full_w);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx       = tx_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign busy     = (state_q != S_IDLE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random bytes, decoded off the tx line by a
// behavioural receiver and compared against the queue of bytes the FIFO should accept.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx;
    logic          full;
    logic          empty;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rxd;
    int         rxt;
    logic [7:0] got[$];
    int         ts[$];
    logic [7:0] exp_q[$];
    logic [7:0] b[10];
    logic [7:0] wd;
    int         peak;
    int         errs;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .tx      (tx),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels of one whole frame, start bit first.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // Called at a negedge; drives one write strobe for the next rising edge.
    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Called at the negedge where tx is first seen low; checks every cycle of the frame.
    task automatic wave_frame(input string tag, input logic [7:0] d);
        logic [10:0] f;
        int e;
        f = frame_bits(d);
        e = 0;
        for (int i = 0; i < FB * CPB; i++) begin
            if (tx !== f[i / CPB] || busy !== 1'b1) e++;
            @(negedge clk);
        end
        chk(tag, e, 0);
    endtask

    // Behavioural receiver: find a falling edge, sample each bit mid-cell.
    task automatic rx_frame(output logic [7:0] d, output int t0);
        bit ok;
        logic [10:0] line;
        ok   = 1'b0;
        t0   = 0;
        d    = 8'h00;
        line = '1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                t0 = cyc;
            end
        end
        chk("rx_frame_seen", ok, 1);
        if (ok) begin
            repeat (CPB / 2) @(negedge clk);
            line[0] = tx;
            for (int j = 1; j < FB; j++) begin
                repeat (CPB) @(negedge clk);
                line[j] = tx;
            end
            d = line[8:1];
            chk("rx_start_bit", line[0], 0);
            chk("rx_stop_bit", line[FB-1], 1);
`ifdef UART_TX_PARITY_EN
            chk("rx_parity_bit", line[9], ^d);
`endif
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, applied asynchronously
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single byte: tx falls one cycle after count reaches 1
        write_byte(8'h55);
        chk("t1_count_after_write", count, 1);
        chk("t1_tx_still_idle", tx, 1);
        @(negedge clk);
        chk("t1_tx_start", tx, 0);
        chk("t1_count_popped", count, 0);
        wave_frame("t1_wave_55", 8'h55);
        chk("t1_busy_done", busy, 0);
        chk("t1_empty_done", empty, 1);
        $display("step single 0x55 done");

        // Byte 0x07: checks parity bit when that feature is built in
        write_byte(8'h07);
        @(negedge clk);
        wave_frame("t1_wave_07", 8'h07);
        chk("t1b_busy_done", busy, 0);
        $display("step single 0x07 done");

        // Three consecutive writes -> back-to-back frames
        got.delete();
        ts.delete();
        peak = 0;
        fork
            begin
                write_byte(8'hA3);
                write_byte(8'h0F);
                write_byte(8'hFF);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    rx_frame(rxd, rxt);
                    got.push_back(rxd);
                    ts.push_back(rxt);
                end
            end
            begin
                repeat (3 * FB * CPB + 10) begin
                    @(negedge clk);
                    if (int'(count) > peak) peak = int'(count);
                end
            end
        join
        chk("t2_byte0", got[0], 8'hA3);
        chk("t2_byte1", got[1], 8'h0F);
        chk("t2_byte2", got[2], 8'hFF);
        chk("t2_gap01", ts[1] - ts[0], FB * CPB);
        chk("t2_gap12", ts[2] - ts[1], FB * CPB);
        chk("t2_peak_count", peak, 2);
        chk("t2_idle", busy, 0);
        $display("step back-to-back done");

        // Ten writes while idle: one popped, eight stored, last dropped;
        // then a write that coincides with the first STOP-end pop is also dropped.
        for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
        got.delete();
        ts.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    wr_en   = 1'b1;
                    wr_data = b[i];
                    @(negedge clk);
                end
                wr_en = 1'b0;
                chk("t3_full", full, 1);
                chk("t3_count_full", count, DEPTH);
                chk("t3_overflow", overflow, 1);
                repeat (FB * CPB - 9) @(negedge clk);
                wr_en   = 1'b1;
                wr_data = 8'hEE;
                @(negedge clk);
                wr_en = 1'b0;
                chk("t4_count_after_pop", count, DEPTH - 1);
                chk("t4_full_after_pop", full, 0);
                chk("t4_overflow_sticky", overflow, 1);
                chk("t4_next_start", tx, 0);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame(rxd, rxt);
                    got.push_back(rxd);
                end
            end
        join
        errs = 0;
        for (int i = 0; i < 9; i++) if (got[i] !== b[i]) errs++;
        chk("t3_data_order", errs, 0);
        errs = 0;
        repeat (FB * CPB + 10) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        chk("t3_no_extra_frame", errs, 0);
        chk("t3_empty_end", empty, 1);
        chk("t3_overflow_end", overflow, 1);
        $display("step overflow done");

        // Random bytes at random spacing, never enough to fill the FIFO
        exp_q.delete();
        ts.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wd = 8'($urandom);
                    exp_q.push_back(wd);
                    write_byte(wd);
                    repeat ($urandom_range(0, 50)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    rx_frame(rxd, rxt);
                    ts.push_back(rxt);
                    chk("rnd_byte", rxd, exp_q.pop_front());
                    if (i > 0) chk("rnd_spacing", (ts[i] - ts[i-1]) >= FB * CPB, 1);
                end
            end
        join
        $display("step random done");
        repeat (FB * CPB) @(negedge clk);

        // Asynchronous reset in the middle of data bit 3 of 0x81
        write_byte(8'h81);
        write_byte(8'h42);
        chk("t5_tx_start", tx, 0);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("t5_tx_bit3", tx, 0);
        chk("t5_count_before", count, 1);
        rst = 1'b0;
        #1;
        chk("t5_tx_rst", tx, 1);
        chk("t5_busy_rst", busy, 0);
        chk("t5_count_rst", count, 0);
        chk("t5_overflow_rst", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        errs = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        chk("t5_quiet_after_rst", errs, 0);
        chk("t5_empty_after_rst", empty, 1);
        $display("step reset mid-frame done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
